// File: rtl/fan_monitor.sv
// fan_monitor: multi-channel fan tachometer monitor.
// Each tach input is synchronised and glitch-filtered. Its rising edges are
// counted over a fixed window of REFCLK_HZ cycles and converted to RPM.
// A sticky stall alarm is raised when an enabled channel reads below min_rpm.
//
// Ports
//   clk, rst     : sole clock; synchronous active-high reset
//   tach         : asynchronous tach inputs, one bit per fan
//   min_rpm      : stall threshold shared by all channels
//   alarm_en     : per-channel alarm enable
//   alarm_clear  : per-channel sticky-alarm clear (one-cycle pulse)
//   rpm          : packed RPM results, channel i in [16i+15:16i]
//   rpm_valid    : high once the first full window has been reported
//   rpm_update   : one-cycle strobe in the cycle rpm is reloaded
//   alarm, irq   : sticky stall flags and their registered OR

module fan_monitor_chan #(
  parameter int FILTER_LEN = 16,
  parameter int RPM_SHIFT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tach,
  input  logic        primed,
  input  logic        term,
  input  logic        load,
  input  logic [15:0] min_rpm,
  input  logic        alarm_en,
  input  logic        alarm_clear,
  output logic [15:0] rpm,
  output logic        alarm
);
  logic [1:0]  sync;
  logic        filt, armed;
  logic [7:0]  fcnt;
  logic [15:0] ecnt, cap;
  logic        eff, differ, accept, rise, set;
  logic [21:0] c22, prod, scaled;
  logic [15:0] rpm_new;

  always_comb begin
    // Until a low level has been accepted the filter behaves as if the level
    // were high, so a tach already high at reset release is not an edge.
    eff     = armed ? filt : 1'b1;
    // Ignore the sync stages until they hold real tach samples.
    differ  = primed && (sync[1] != eff);
    accept  = differ && (fcnt == 8'(FILTER_LEN - 1));
    rise    = accept && armed && sync[1];
    // x60 as (c<<6)-(c<<2), then divide by pulses/rev with a shift.
    c22     = {6'd0, cap};
    prod    = (c22 << 6) - (c22 << 2);
    scaled  = prod >> RPM_SHIFT;
    rpm_new = (|scaled[21:16]) ? 16'hFFFF : scaled[15:0];
    set     = load && alarm_en && (rpm_new < min_rpm);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      filt  <= 1'b0;
      armed <= 1'b0;
      fcnt  <= '0;
      ecnt  <= '0;
      cap   <= '0;
      rpm   <= '0;
      alarm <= 1'b0;
    end else begin
      sync <= {sync[0], tach};
      fcnt <= (differ && !accept) ? fcnt + 8'd1 : 8'd0;
      if (accept) begin
        if (armed) filt  <= sync[1];
        else       armed <= 1'b1;
      end
      // An edge on the terminal cycle opens the next window.
      if (term) begin
        cap  <= ecnt;
        ecnt <= {15'd0, rise};
      end else if (rise && ecnt != 16'hFFFF) begin
        ecnt <= ecnt + 16'd1;
      end
      if (load) rpm <= rpm_new;
      alarm <= set || (alarm && !alarm_clear);
    end
  end
endmodule

module fan_monitor #(
  parameter int NUM_FANS       = 2,
  parameter int REFCLK_HZ      = 187500000,
  parameter int PULSES_PER_REV = 2,
  parameter int FILTER_LEN     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FANS-1:0]   tach,
  input  logic [15:0]           min_rpm,
  input  logic [NUM_FANS-1:0]   alarm_en,
  input  logic [NUM_FANS-1:0]   alarm_clear,
  output logic [NUM_FANS*16-1:0] rpm,
  output logic                  rpm_valid,
  output logic                  rpm_update,
  output logic [NUM_FANS-1:0]   alarm,
  output logic                  irq
);
  localparam int WCW = (REFCLK_HZ > 1) ? $clog2(REFCLK_HZ) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(REFCLK_HZ - 1);
  localparam int RPM_SHIFT = (PULSES_PER_REV == 4) ? 2 :
                             (PULSES_PER_REV == 2) ? 1 : 0;

  // vld_pipe[1] marks that the second sync stage holds a post-reset sample.
  logic [1:0]     vld_pipe;
  logic [WCW-1:0] wcnt;
  logic           term, term_q;

  assign term = (wcnt == WLAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe   <= '0;
      wcnt       <= '0;
      term_q     <= 1'b0;
      rpm_update <= 1'b0;
      rpm_valid  <= 1'b0;
      irq        <= 1'b0;
    end else begin
      vld_pipe   <= {vld_pipe[0], 1'b1};
      wcnt       <= term ? '0 : wcnt + WCW'(1);
      term_q     <= term;
      rpm_update <= term_q;
      rpm_valid  <= rpm_valid | term_q;
      irq        <= |alarm;
    end
  end

  for (genvar i = 0; i < NUM_FANS; i++) begin : g_chan
    fan_monitor_chan #(
      .FILTER_LEN (FILTER_LEN),
      .RPM_SHIFT  (RPM_SHIFT)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .tach        (tach[i]),
      .primed      (vld_pipe[1]),
      .term        (term),
      .load        (term_q),
      .min_rpm     (min_rpm),
      .alarm_en    (alarm_en[i]),
      .alarm_clear (alarm_clear[i]),
      .rpm         (rpm[16*i +: 16]),
      .alarm       (alarm[i])
    );
  end
endmodule

// File: tb/tb_fan_monitor.sv
// Bench for fan_monitor: main DUT (2 fans, 1000-cycle window, filter 4,
// 2 pulses/rev) against a window-level reference model, plus a second DUT
// (3000-cycle window, filter 1, 1 pulse/rev) for RPM saturation.
module tb_fan_monitor;
  localparam int NF = 2, R = 1000, FL = 4, PPR = 2;
  localparam int R2 = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, rst2;
  logic [NF-1:0]     tach, alarm_en, alarm_clear;
  logic [15:0]       min_rpm;
  logic [NF*16-1:0]  rpm;
  logic              rpm_valid, rpm_update, irq;
  logic [NF-1:0]     alarm;
  logic              tach2, valid2, upd2, alarm2, irq2;
  logic [15:0]       rpm2;

  fan_monitor #(.NUM_FANS(NF), .REFCLK_HZ(R), .PULSES_PER_REV(PPR), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst(rst), .tach(tach), .min_rpm(min_rpm), .alarm_en(alarm_en),
    .alarm_clear(alarm_clear), .rpm(rpm), .rpm_valid(rpm_valid),
    .rpm_update(rpm_update), .alarm(alarm), .irq(irq));

  fan_monitor #(.NUM_FANS(1), .REFCLK_HZ(R2), .PULSES_PER_REV(1), .FILTER_LEN(1)) dut2 (
    .clk(clk), .rst(rst2), .tach(tach2), .min_rpm(16'd0), .alarm_en(1'b0),
    .alarm_clear(1'b0), .rpm(rpm2), .rpm_valid(valid2),
    .rpm_update(upd2), .alarm(alarm2), .irq(irq2));

  int total = 0, bad = 0;
  int cyc, cyc2, upd_seen, mode, ph;
  int hold [NF];

  // reference model state
  bit          d1 [NF], d2 [NF], run_v [NF], acc [NF];
  int          run_len [NF];
  int          win_cnt [NF][64];
  logic [15:0] rpm_m [NF];
  bit          valid_m, upd_m, irq_m;
  logic [NF-1:0] alm_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] scale(input int c);
    int v;
    v = c * 60 / PPR;
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  task automatic model_rst();
    cyc = 0;
    for (int c = 0; c < NF; c++) begin
      d1[c] = 0; d2[c] = 0; run_v[c] = 0; run_len[c] = 0;
      acc[c] = 1;  // level unknown until a low is seen
      rpm_m[c] = '0;
      for (int w = 0; w < 64; w++) win_cnt[c][w] = 0;
    end
    valid_m = 0; upd_m = 0; irq_m = 0; alm_m = '0;
  endtask

  // Edges are accepted from runs of FL equal synchronised samples and binned
  // into the window floor(cycle/R); results appear the cycle after each wrap.
  task automatic model_step();
    bit v, rise;
    int w;
    logic [NF-1:0] set;
    cyc++;
    for (int c = 0; c < NF; c++) begin
      rise = 0;
      if (cyc >= 3) begin
        v = d2[c];
        if (run_len[c] > 0 && v == run_v[c]) run_len[c]++;
        else begin run_v[c] = v; run_len[c] = 1; end
        if (run_len[c] == FL && v != acc[c]) begin rise = v; acc[c] = v; end
      end
      d2[c] = d1[c]; d1[c] = tach[c];
      w = cyc / R;
      if (rise && w < 64 && win_cnt[c][w] < 65535) win_cnt[c][w]++;
    end
    upd_m = (cyc > R) && (cyc % R == 1);
    irq_m = |alm_m;
    set = '0;
    if (upd_m) begin
      w = (cyc - 1) / R - 1;
      valid_m = 1;
      for (int c = 0; c < NF; c++) begin
        rpm_m[c] = scale(win_cnt[c][w]);
        set[c]   = alarm_en[c] && (rpm_m[c] < min_rpm);
      end
    end
    alm_m = set | (alm_m & ~alarm_clear);
  endtask

  task automatic tick();
    for (int c = 0; c < NF; c++) begin
      case (mode)
        0: tach[c] = 1'b0;
        1: tach[c] = (c == 0) ? ((ph % 10) < 5) : 1'b0;
        2: tach[c] = (c == 0) ? ((ph % 20) < 2) : 1'b0;
        3: begin
          if (hold[c] <= 0) begin tach[c] = ~tach[c]; hold[c] = $urandom_range(1, 12); end
          hold[c]--;
        end
        default: tach[c] = 1'b1;
      endcase
    end
    if (mode == 3) alarm_clear = ($urandom_range(0, 63) == 0) ? NF'($urandom) : '0;
    @(posedge clk);
    if (!rst2) cyc2++;
    if (rst) model_rst(); else model_step();
    @(negedge clk);
    if (rpm_update) upd_seen++;
    chk("upd", rpm_update, upd_m);
    chk("valid", rpm_valid, valid_m);
    chk("rpm0", rpm[15:0], rpm_m[0]);
    chk("rpm1", rpm[31:16], rpm_m[1]);
    chk("alarm", alarm, alm_m);
    chk("irq", irq, irq_m);
    chk("upd2", upd2, (cyc2 > R2) && (cyc2 % R2 == 1));
    chk("rpm2", rpm2, (cyc2 > R2) ? 16'hFFFF : 16'h0);
    chk("alarm2", {alarm2, irq2}, 2'b00);
    tach2 = ~tach2;
    ph++;
  endtask

  initial begin
    int snap;
    rst = 1; rst2 = 1; tach = '0; tach2 = 0; alarm_en = '0; alarm_clear = '0;
    min_rpm = '0; mode = 0; ph = 0; cyc2 = 0; upd_seen = 0;
    for (int c = 0; c < NF; c++) hold[c] = 0;
    model_rst();
    repeat (3) tick();
    rst = 0; rst2 = 0;

    // idle from reset: one update at cycle R+1, zero rpm, no alarm
    repeat (R + 5) tick();
    chk("a_nupd", upd_seen, 1);
    chk("a_valid", rpm_valid, 1);
    chk("a_rpm0", rpm[15:0], 0);

    // square wave, period 10
    mode = 1; ph = 0;
    repeat (2 * R + 2) tick();
    chk("b_rpm0", rpm[15:0], 3000);
    chk("b_rpm1", rpm[31:16], 0);

    // 2-cycle glitches are filtered out
    mode = 0; repeat (20) tick();
    mode = 2; ph = 0;
    repeat (2 * R + 2) tick();
    chk("c_rpm0", rpm[15:0], 0);

    // stall alarm on fan1
    mode = 0; repeat (20) tick();
    min_rpm = 16'd1000; alarm_en = 2'b10; mode = 1; ph = 0;
    repeat (2 * R + 2) tick();
    chk("d_alarm", alarm, 2'b10);
    chk("d_irq", irq, 1);
    chk("d_rpm0", rpm[15:0], 3000);
    while (cyc % R != 500) tick();
    alarm_clear = 2'b10; tick(); alarm_clear = '0;
    chk("d_clr", alarm[1], 0);
    tick();
    chk("d_irq_clr", irq, 0);
    while (cyc % R != 0) tick();
    alarm_clear = 2'b10; tick(); alarm_clear = '0;
    chk("d_upd", rpm_update, 1);
    chk("d_setwins", alarm[1], 1);

    // randomised traffic, enables and thresholds
    mode = 3;
    for (int w = 0; w < 5; w++) begin
      alarm_en = NF'($urandom);
      min_rpm  = 16'($urandom_range(500, 3000));
      repeat (R) tick();
    end

    // reset mid-window with edges; tach held high over release
    while (cyc % R != 500) tick();
    alarm_clear = '0;
    rst = 1; mode = 4; repeat (3) tick(); rst = 0;
    snap = upd_seen;
    repeat (R) tick();
    chk("f_early", upd_seen - snap, 0);
    tick();
    chk("f_upd", upd_seen - snap, 1);
    chk("f_rpm0_high", rpm[15:0], 0);
    chk("f_rpm1_high", rpm[31:16], 0);

    // reset mid-window again, then random traffic counted from release
    mode = 3;
    while (cyc % R != 500) tick();
    alarm_clear = '0;
    rst = 1; repeat (2) tick(); rst = 0;
    snap = upd_seen;
    repeat (R) tick();
    chk("g_early", upd_seen - snap, 0);
    repeat (R + 5) tick();
    chk("g_nupd", upd_seen - snap, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
